// File: rtl/discrete_iir_node_pkg.sv
// Shared state type and fixed-point helpers for discrete_iir_node.
// Define DISCRETE_NODE_SAT_EN to saturate the node result instead of wrapping it.
package discrete_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StMac, StUpdate} state_e;

  // Wide enough for n_in + 1 full-scale products, so the running sum cannot overflow.
  function automatic int unsigned acc_width(int unsigned n_in, int unsigned width,
                                            int unsigned cw);
    return width + cw + $clog2(n_in + 1);
  endfunction

  // Reduces a post-shift value to a width-bit signed result, sign-extended to 64 bits.
  function automatic logic signed [63:0] reduce_result(logic signed [63:0] v,
                                                      int unsigned width);
`ifdef DISCRETE_NODE_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - width)) >>> (64 - width);
`endif
  endfunction

endpackage

// File: rtl/discrete_iir_node_if.sv
// Sample, coefficient-load and result signals of one discrete_iir_node.
interface discrete_iir_node_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 16
) ();

  logic                      sample_stb;
  logic [N_IN*WIDTH-1:0]     x_in;
  logic                      coef_we;
  logic [3:0]                coef_addr;
  logic signed [CW-1:0]      coef_data;
  logic                      overrun_clr;
  logic signed [WIDTH-1:0]   y_out;
  logic                      y_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output sample_stb, x_in, coef_we, coef_addr, coef_data, overrun_clr,
    input  y_out, y_valid, busy, overrun
  );

  modport slave (
    input  sample_stb, x_in, coef_we, coef_addr, coef_data, overrun_clr,
    output y_out, y_valid, busy, overrun
  );

endinterface

// File: rtl/discrete_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module discrete_mac #(
  parameter int unsigned AW = 34,
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] data_i,
  output logic signed [AW-1:0] acc_o
);

  localparam int unsigned PW = DW + CW;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_d, acc_q;

  always_comb begin
    prod  = PW'(coef_i) * PW'(data_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AW - PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/discrete_iir_node.sv
// First-order node y[n] = a*y[n-1] + sum b_i*x_i[n] using one time-multiplexed multiplier.
// Result reduction (saturate vs wrap) is selected by DISCRETE_NODE_SAT_EN.
module discrete_iir_node
  import discrete_pkg::*;
#(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned CFRAC = 12
) (
  input logic                clk_msdsl,
  input logic                rst_msdsl_n,
  discrete_iir_node_if.slave bus
);

  localparam int unsigned AW = acc_width(N_IN, WIDTH, CW);
  localparam int unsigned KW = $clog2(N_IN + 1);

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [CW-1:0]    shadow_q [N_IN+1];
  logic signed [CW-1:0]    shadow_d [N_IN+1];
  logic signed [CW-1:0]    active_q [N_IN+1];
  logic signed [CW-1:0]    active_d [N_IN+1];
  logic signed [WIDTH-1:0] x_q [N_IN];
  logic signed [WIDTH-1:0] x_d [N_IN];
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    overrun_q, overrun_d;

  logic                    mac_clr, mac_en;
  logic signed [CW-1:0]    mac_coef;
  logic signed [WIDTH-1:0] mac_data;
  logic signed [AW-1:0]    acc;
  logic signed [63:0]      acc_ext;
  logic signed [WIDTH-1:0] result;

  discrete_mac #(
    .AW(AW),
    .DW(WIDTH),
    .CW(CW)
  ) u_mac (
    .clk_i (clk_msdsl),
    .rst_ni(rst_msdsl_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .coef_i(mac_coef),
    .data_i(mac_data),
    .acc_o (acc)
  );

  always_comb begin
    acc_ext = {{(64 - AW){acc[AW-1]}}, acc};
    result  = WIDTH'(reduce_result(acc_ext >>> CFRAC, WIDTH));
  end

  // Term 0 is the feedback a*y, terms 1..N_IN are b_(k-1)*x_(k-1).
  always_comb begin
    mac_coef = '0;
    mac_data = y_q;
    for (int unsigned i = 0; i <= N_IN; i++) begin
      if (k_q == KW'(i)) mac_coef = active_q[i];
    end
    for (int unsigned i = 1; i <= N_IN; i++) begin
      if (k_q == KW'(i)) mac_data = x_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    y_d       = y_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    x_d       = x_q;
    overrun_d = overrun_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;

    if (bus.overrun_clr) overrun_d = 1'b0;

    if (bus.coef_we) begin
      for (int unsigned i = 0; i <= N_IN; i++) begin
        if (bus.coef_addr == 4'(i)) shadow_d[i] = bus.coef_data;
      end
    end

    case (state_q)
      StIdle: begin
        if (bus.sample_stb) begin
          // shadow_d so that a write in the accepting cycle is part of this step
          active_d = shadow_d;
          for (int unsigned i = 0; i < N_IN; i++) begin
            x_d[i] = bus.x_in[i*WIDTH +: WIDTH];
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        mac_clr = 1'b1;
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        mac_en = 1'b1;
        if (k_q == KW'(N_IN)) begin
          state_d = StUpdate;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StUpdate: begin
        y_d     = result;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A dropped strobe beats a simultaneous clear.
    if (bus.sample_stb && (state_q != StIdle)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_msdsl or negedge rst_msdsl_n) begin
    if (!rst_msdsl_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      y_q       <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i <= N_IN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int unsigned i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      y_q       <= y_d;
      overrun_q <= overrun_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      x_q       <= x_d;
    end
  end

  // The new value is already visible in the y_valid cycle; y_q holds it afterwards.
  assign bus.y_out   = (state_q == StUpdate) ? result : y_q;
  assign bus.y_valid = (state_q == StUpdate);
  assign bus.busy    = (state_q != StIdle);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_discrete_iir_node.sv
// Randomised self-checking bench for discrete_iir_node against an arithmetic reference model.
module tb_discrete_iir_node;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int CWID  = 16;
  localparam int CFRAC = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  discrete_iir_node_if #(.N_IN(N), .WIDTH(W), .CW(CWID)) bus ();

  discrete_iir_node #(
    .N_IN (N),
    .WIDTH(W),
    .CW   (CWID),
    .CFRAC(CFRAC)
  ) dut (
    .clk_msdsl  (clk),
    .rst_msdsl_n(rst_n),
    .bus        (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  int m_shadow [N+1];
  int m_active [N+1];
  int m_y;

  function automatic int model_reduce(input longint s);
    longint lim;
    longint m;
    lim = longint'(1) << (W - 1);
`ifdef DISCRETE_NODE_SAT_EN
    m = s;
    if (s > lim - 1) m = lim - 1;
    if (s < -lim) m = -lim;
`else
    m = ((s % (2 * lim)) + 2 * lim) % (2 * lim);
    if (m >= lim) m = m - 2 * lim;
`endif
    return int'(m);
  endfunction

  task automatic model_clear();
    m_y = 0;
    for (int i = 0; i <= N; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  task automatic model_write(input int addr, input int data);
    if (addr >= 0 && addr <= N) m_shadow[addr] = data;
  endtask

  task automatic model_update(input int xs[N], output int exp_y);
    longint acc;
    m_active = m_shadow;
    acc = longint'(m_active[0]) * longint'(m_y);
    for (int i = 0; i < N; i++) acc += longint'(m_active[i+1]) * longint'(xs[i]);
    m_y   = model_reduce(acc >>> CFRAC);
    exp_y = m_y;
  endtask

  function automatic logic [N*W-1:0] pack_x(input int xs[N]);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(xs[i]);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.sample_stb  = 1'b0;
    bus.x_in        = '0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    bus.overrun_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(addr);
    bus.coef_data = CWID'(data);
    model_write(addr, data);
    @(posedge clk);
    #1 bus.coef_we = 1'b0;
  endtask

  // Strobe once, check latency, result and the cycle after; returns with busy low.
  task automatic run_step(input int xs[N], input bit wr, input int waddr, input int wdata,
                          input string name);
    int exp_y;
    bit seen;
    int n;
    bus.x_in       = pack_x(xs);
    bus.sample_stb = 1'b1;
    if (wr) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(waddr);
      bus.coef_data = CWID'(wdata);
      model_write(waddr, wdata);
    end
    model_update(xs, exp_y);
    @(posedge clk);
    #1;
    bus.sample_stb = 1'b0;
    bus.coef_we    = 1'b0;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        n_run++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
        end
      end
      if (bus.y_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_run++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s y_valid_timeout: got none within 20 cycles want %0d", name, N + 3);
    end else begin
      if (n !== N + 3) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d", name, n, N + 3);
      end
      n_run++;
      if (bus.y_out !== W'(exp_y)) begin
        n_fail++;
        $display("FAIL %s y_out: got %0d want %0d", name, $signed(bus.y_out), exp_y);
      end
      @(posedge clk);
      #1;
      n_run++;
      if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after_update: got valid=%b busy=%b want 0 0", name, bus.y_valid,
                 bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_run++;
    if (bus.y_out !== '0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got y=%0d v=%b b=%b o=%b want 0 0 0 0",
               $signed(bus.y_out), bus.y_valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_pass_through();
    int xs[N];
    write_coef(0, 0);
    write_coef(1, 4096);
    xs[0] = 1000; xs[1] = $urandom_range(0, 999); xs[2] = $urandom_range(0, 999);
    run_step(xs, 1'b0, 0, 0, "pass_through");
    n_run++;
    if (bus.y_out !== 16'sd1000) begin
      n_fail++;
      $display("FAIL pass_through_hold: got %0d want 1000", $signed(bus.y_out));
    end
  endtask

  task automatic test_hold();
    int xs[N];
    write_coef(0, 4096);
    write_coef(1, 0);
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 65535)) - 32768;
      run_step(xs, 1'b0, 0, 0, "hold");
      n_run++;
      if (bus.y_out !== 16'sd1000) begin
        n_fail++;
        $display("FAIL hold_value: got %0d want 1000", $signed(bus.y_out));
      end
    end
  endtask

  task automatic test_lowpass();
    int xs[N];
    int want[4];
    want[0] = 500; want[1] = 750; want[2] = 875; want[3] = 937;
    apply_reset();
    write_coef(0, 2048);
    write_coef(1, 2048);
    xs[0] = 1000; xs[1] = 0; xs[2] = 0;
    for (int s = 0; s < 4; s++) begin
      run_step(xs, 1'b0, 0, 0, "lowpass");
      n_run++;
      if (bus.y_out !== W'(want[s])) begin
        n_fail++;
        $display("FAIL lowpass_seq%0d: got %0d want %0d", s, $signed(bus.y_out), want[s]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_overflow();
    int xs[N];
    int want;
`ifdef DISCRETE_NODE_SAT_EN
    want = 32767;
`else
    want = -5536;
`endif
    write_coef(0, 0);
    write_coef(1, 4096);
    write_coef(2, 4096);
    write_coef(3, 0);
    xs[0] = 30000; xs[1] = 30000; xs[2] = 0;
    run_step(xs, 1'b0, 0, 0, "overflow");
    n_run++;
    if (bus.y_out !== W'(want)) begin
      n_fail++;
      $display("FAIL overflow_value: got %0d want %0d", $signed(bus.y_out), want);
    end
  endtask

  task automatic test_overrun_shadow();
    int xs[N];
    int exp_y;
    int valids;
    write_coef(0, 0);
    write_coef(1, 4096);
    write_coef(2, 0);
    bus.overrun_clr = 1'b1;
    @(posedge clk);
    #1 bus.overrun_clr = 1'b0;
    xs[0] = 100; xs[1] = $urandom_range(1, 500); xs[2] = 7;
    bus.x_in = pack_x(xs);
    bus.sample_stb = 1'b1;
    model_update(xs, exp_y);
    @(posedge clk);
    #1 bus.sample_stb = 1'b0;
    @(posedge clk);
    // Second strobe lands mid-step together with a b0 write.
    #1;
    bus.sample_stb = 1'b1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd1;
    bus.coef_data  = '0;
    model_write(1, 0);
    @(posedge clk);
    #1;
    bus.sample_stb = 1'b0;
    bus.coef_we    = 1'b0;
    valids = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) begin
        valids++;
        n_run++;
        if (bus.y_out !== W'(exp_y)) begin
          n_fail++;
          $display("FAIL overrun_first_result: got %0d want %0d", $signed(bus.y_out), exp_y);
        end
      end
      @(posedge clk);
      #1;
    end
    n_run++;
    if (valids !== 1) begin
      n_fail++;
      $display("FAIL overrun_valid_count: got %0d want 1", valids);
    end
    n_run++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b want 1", bus.overrun);
    end
    bus.sample_stb = 1'b1;
    model_update(xs, exp_y);
    @(posedge clk);
    #1;
    bus.overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_stb = 1'b0;
    n_run++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_clr_collision: got %b want 1", bus.overrun);
    end
    @(posedge clk);
    #1 bus.overrun_clr = 1'b0;
    n_run++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clr: got %b want 0", bus.overrun);
    end
    valids = 0;
    for (int c = 0; c < 10 && valids == 0; c++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) valids++;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_run++;
    if (valids !== 1 || bus.y_out !== W'(exp_y)) begin
      n_fail++;
      $display("FAIL shadow_applied: got valids=%0d y=%0d want 1 %0d", valids,
               $signed(bus.y_out), exp_y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_step();
    int xs[N];
    int valids;
    int dummy;
    write_coef(0, 4096);
    write_coef(1, 4096);
    xs[0] = 321; xs[1] = 0; xs[2] = 0;
    bus.x_in = pack_x(xs);
    bus.sample_stb = 1'b1;
    model_update(xs, dummy);
    @(posedge clk);
    #1 bus.sample_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    n_run++;
    if (bus.y_out !== '0 || bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midstep_reset: got y=%0d b=%b v=%b want 0 0 0", $signed(bus.y_out),
               bus.busy, bus.y_valid);
    end
    valids = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1) valids++;
      if (c == 2) rst_n = 1'b1;
    end
    n_run++;
    if (valids !== 0) begin
      n_fail++;
      $display("FAIL midstep_no_valid: got %0d want 0", valids);
    end
    @(posedge clk);
    #1;
    write_coef(1, 4096);
    xs[0] = 1234;
    run_step(xs, 1'b0, 0, 0, "after_reset");
  endtask

  // Steps issued at minimum spacing with random coefficients and writes.
  task automatic test_back_to_back_random();
    int xs[N];
    bit wr;
    int waddr;
    int wdata;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        write_coef(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768);
      end
      for (int i = 0; i < N; i++) xs[i] = int'($urandom_range(0, 65535)) - 32768;
      wr    = 1'($urandom_range(0, 1));
      waddr = int'($urandom_range(0, 6));
      wdata = int'($urandom_range(0, 65535)) - 32768;
      run_step(xs, wr, waddr, wdata, "random");
    end
    n_run++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL min_spacing_overrun: got %b want 0", bus.overrun);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_pass_through();
    test_hold();
    test_lowpass();
    test_overflow();
    test_overrun_shadow();
    test_reset_mid_step();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/discrete_iir_node.md
Name: discrete_iir_node

Overview:
- Parametrised first-order discrete-time circuit node computing y[n] = a*y[n-1] + sum_i b_i*x_i[n] in signed fixed point.
- Generalises the generated single-node, fixed-coefficient, three-input model: N_IN inputs, runtime-loadable coefficients, sample-strobe pacing, time-multiplexed single multiplier, overflow handling.
- Sits between input stages (555 outputs, supply rails) and downstream mixers in the discrete audio chain.

Parameters:
- N_IN, 3, number of driving inputs x_i (1..15)
- WIDTH, 16, signal width, signed two's complement
- CW, 16, coefficient width, signed
- CFRAC, 12, coefficient fractional bits (4096 = 1.0 at default)

Ports:
- clk_msdsl  in  1  system clock
- rst_msdsl_n  in  1  asynchronous reset, active-low
- sample_stb  in  1  one-cycle pulse: start one update step
- x_in  in  N_IN*WIDTH  packed inputs; x_0 in bits [WIDTH-1:0]
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  0 = a (feedback), 1..N_IN = b_(addr-1)
- coef_data  in  CW  coefficient value
- overrun_clr  in  1  clears overrun flag
- y_out  out  WIDTH  node state y[n]
- y_valid  out  1  one-cycle pulse when y_out updates
- busy  out  1  high while a step is in progress
- overrun  out  1  sticky: sample_stb arrived while busy

Behaviour:
- Reset (asynchronous, rst_msdsl_n low): y_out=0, y_valid=0, busy=0, overrun=0, state IDLE, accumulator=0, active and shadow coefficient banks all 0. Reset mid-step aborts the step; no y_valid.
- Coefficient writes go to the shadow bank every cycle coef_we=1. coef_addr > N_IN is ignored. On sample_stb acceptance, shadow is copied to the active bank. A write in the same cycle as an accepted strobe is included in the copy.
- FSM: IDLE -> (sample_stb) LOAD -> MAC x(N_IN+1 cycles) -> UPDATE -> IDLE.
  - LOAD: latch x_in into hold registers, copy shadow->active, clear accumulator, busy=1.
  - MAC: term k=0 is a*y_out; terms k=1..N_IN are b_(k-1)*x_(k-1); one product per cycle.
  - UPDATE: y_out <= result, y_valid=1 for exactly this cycle, busy=0 on the following cycle.
- Latency: strobe accepted in cycle t -> y_valid in cycle t+N_IN+3 (t+6 at default). Minimum strobe spacing is N_IN+4 cycles.
- sample_stb while busy=1 (LOAD..UPDATE) is dropped and sets overrun=1. overrun_clr=1 clears it; a simultaneous overrun event wins (flag stays 1).
- Arithmetic:
  - Products are WIDTH+CW bits.
  - Accumulator width is WIDTH+CW+clog2(N_IN+1); it never overflows.
  - Result = acc >>> CFRAC (arithmetic shift, truncates toward -inf), then reduced to WIDTH bits as defined under Optional Feature.

Optional Feature:
- Macro DISCRETE_NODE_SAT_EN.
- Defined: the result saturates to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1].
- Undefined: keep the low WIDTH bits (two's complement wrap), matching the legacy generated models.

Decomposition:
- Package discrete_pkg: state enum (IDLE, LOAD, MAC, UPDATE), accumulator-width function, saturate/wrap function.
- One sub-module, discrete_mac: registered multiply-accumulate with clear/enable, reused by later nodes.

Test Plan (defaults, SAT_EN defined unless stated):
- Pass-through: a=0, b0=4096, x0=1000, others 0; pulse strobe -> y_valid 6 cycles later, y_out=1000.
- Hold: a=4096, all b=0, y_out=1000; strobe x3 -> y_out stays 1000 each time.
- Low-pass: a=2048, b0=2048, x0=1000, from reset; strobes spaced 8 cycles -> y_out sequence 500, 750, 875, 937.
- Overflow: a=0, b0=b1=4096, x0=x1=30000 -> y_out=32767; rebuilt without SAT_EN -> y_out=-5536.
- Overrun/shadow: strobe, then write b0=0 and strobe again 2 cycles later -> first result uses the old b0, overrun=1, one y_valid only; overrun_clr -> overrun=0.
- Reset mid-step: drop rst_msdsl_n during MAC -> y_out=0, busy=0, no y_valid; the next strobe after release runs normally.
